// File: rtl/adc_reader.sv
// adc_reader: polls a 4-channel ADC controller over a UART link and
// keeps the latest 10-bit conversion of each channel.
module adc_reader #(
  parameter int CLKS_PER_BIT   = 1250,
  parameter int TIMEOUT_CYCLES = 120000
) (
  input  logic       clock12MHz,
  input  logic       reset,
  input  logic       serialIn,
  output logic       serialOut,
  output logic [9:0] value1,
  output logic [9:0] value2,
  output logic [9:0] value3,
  output logic [9:0] value4
);

  localparam int CW   = $clog2(CLKS_PER_BIT + 1);
  localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HALF = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 : 1;

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE_GAP,
    TX_CMD,
    RX_HI,
    RX_LO,
    UPDATE
  } state_t;

  state_t          state;
  logic            sync1;
  logic            sync2;
  logic            rx_prev;
  logic            rx_fall;
  logic            rx_tick;
  logic [1:0]      chan;
  logic [7:0]      cmd_byte;
  logic [CW-1:0]   bit_cnt;
  logic [CW-1:0]   rx_cnt;
  logic [TW-1:0]   to_cnt;
  logic [8:0]      tx_sh;
  logic [3:0]      tx_idx;
  logic [3:0]      rx_idx;
  logic            rx_busy;
  logic [7:0]      rx_sh;
  logic [1:0]      hi_bits;

  assign rx_fall  = rx_prev & ~sync2;
  assign cmd_byte = 8'hA1 + {6'd0, chan};
  // The start-bit check comes half a bit after the edge; later samples a full bit apart.
  assign rx_tick  = (rx_idx == 4'd0) ? (rx_cnt == HALF_LAST)
                                     : (rx_cnt == BIT_LAST);

  // Two-flop synchronizer plus a delayed copy for falling-edge detection.
  always_ff @(posedge clock12MHz or posedge reset) begin
    if (reset) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= serialIn;
      sync2   <= sync1;
      rx_prev <= sync2;
    end
  end

  // Polling FSM: gap, send command, receive two bytes, then publish the value.
  always_ff @(posedge clock12MHz or posedge reset) begin
    if (reset) begin
      state     <= IDLE_GAP;
      serialOut <= 1'b1;
      value1    <= 10'd0;
      value2    <= 10'd0;
      value3    <= 10'd0;
      value4    <= 10'd0;
      chan      <= 2'd0;
      bit_cnt   <= '0;
      rx_cnt    <= '0;
      to_cnt    <= '0;
      tx_sh     <= 9'd0;
      tx_idx    <= 4'd0;
      rx_idx    <= 4'd0;
      rx_busy   <= 1'b0;
      rx_sh     <= 8'd0;
      hi_bits   <= 2'd0;
    end else begin
      unique case (state)
        IDLE_GAP: begin
          serialOut <= 1'b1;
          rx_busy   <= 1'b0;
          if (bit_cnt == BIT_LAST) begin
            bit_cnt   <= '0;
            serialOut <= 1'b0;
            tx_sh     <= {1'b1, cmd_byte};
            tx_idx    <= 4'd0;
            state     <= TX_CMD;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        TX_CMD: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            if (tx_idx == 4'd9) begin
              to_cnt  <= '0;
              rx_busy <= 1'b0;
              state   <= RX_HI;
            end else begin
              serialOut <= tx_sh[0];
              tx_sh     <= tx_sh >> 1;
              tx_idx    <= tx_idx + 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        RX_HI, RX_LO: begin
          to_cnt <= to_cnt + 1'b1;
          if (to_cnt == TO_LAST) begin
            rx_busy <= 1'b0;
            bit_cnt <= '0;
            chan    <= chan + 1'b1;
            state   <= IDLE_GAP;
          end else if (!rx_busy) begin
            if (rx_fall) begin
              rx_busy <= 1'b1;
              rx_cnt  <= '0;
              rx_idx  <= 4'd0;
            end
          end else if (rx_tick) begin
            rx_cnt <= '0;
            rx_idx <= rx_idx + 1'b1;
            if (rx_idx == 4'd0) begin
              if (sync2) begin
                rx_busy <= 1'b0;
              end
            end else if (rx_idx != 4'd9) begin
              rx_sh <= {sync2, rx_sh[7:1]};
            end else begin
              rx_busy <= 1'b0;
              if (!sync2) begin
                bit_cnt <= '0;
                chan    <= chan + 1'b1;
                state   <= IDLE_GAP;
              end else if (state == RX_HI) begin
                hi_bits <= rx_sh[1:0];
                state   <= RX_LO;
              end else begin
                state <= UPDATE;
              end
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end

        UPDATE: begin
          unique case (chan)
            2'd0: value1 <= {hi_bits, rx_sh};
            2'd1: value2 <= {hi_bits, rx_sh};
            2'd2: value3 <= {hi_bits, rx_sh};
            2'd3: value4 <= {hi_bits, rx_sh};
          endcase
          chan    <= chan + 1'b1;
          bit_cnt <= '0;
          state   <= IDLE_GAP;
        end

        default: begin
          bit_cnt <= '0;
          state   <= IDLE_GAP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_reader.sv
// tb_adc_reader: plays the ADC controller, decodes commands and
// checks the published values against a channel-array model.
module tb_adc_reader;

  localparam int CPB = 4;
  localparam int TO  = 200;

  localparam int K_VALID   = 0;
  localparam int K_TIMEOUT = 1;
  localparam int K_HIERR   = 2;
  localparam int K_LOERR   = 3;
  localparam int K_GLITCH  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       tx;
  logic [9:0] v1, v2, v3, v4;

  int         tests = 0;
  int         fails = 0;
  int         exp_ch = 0;
  logic [9:0] exp_val [4];
  logic       pend_en = 1'b0;
  int         pend_ch = 0;
  logic [9:0] pend_val = 10'd0;
  logic       chk_en = 1'b0;

  logic [7:0] hi_t [4];
  logic [7:0] lo_t [4];

  adc_reader #(
    .CLKS_PER_BIT  (CPB),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock12MHz(clk),
    .reset     (rst),
    .serialIn  (rx),
    .serialOut (tx),
    .value1    (v1),
    .value2    (v2),
    .value3    (v3),
    .value4    (v4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  // Values must match the model; during a reply's final byte the
  // addressed channel may already hold the new value.
  always @(negedge clk) begin
    logic [39:0] act_v;
    logic [39:0] exp_v;
    logic [39:0] alt_v;
    if (chk_en) begin
      act_v = {v4, v3, v2, v1};
      exp_v = {exp_val[3], exp_val[2], exp_val[1], exp_val[0]};
      alt_v = exp_v;
      if (pend_en) alt_v[pend_ch*10 +: 10] = pend_val;
      tests++;
      if (act_v !== exp_v && !(pend_en && act_v === alt_v)) begin
        fails++;
        $display("FAIL values: got %h, expected %h", act_v, exp_v);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic wait_cmd(input logic [7:0] want);
    int n;
    logic [7:0] got;
    logic stp;
    n = 0;
    while (tx !== 1'b0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (tx !== 1'b0) begin
      tests++;
      fails++;
      $display("FAIL cmd_wait: no start bit in %0d cycles, expected cmd %h",
               n, want);
      return;
    end
    repeat (CPB / 2) @(negedge clk);
    chk("cmd_start", tx, 0);
    for (int k = 0; k < 8; k++) begin
      repeat (CPB) @(negedge clk);
      got[k] = tx;
    end
    repeat (CPB) @(negedge clk);
    stp = tx;
    chk("cmd_byte", got, want);
    chk("cmd_stop", stp, 1);
  endtask

  task automatic txn(input int kind, input logic [7:0] hi,
                     input logic [7:0] lo);
    int n;
    wait_cmd(8'hA1 + 8'(exp_ch));
    if (kind == K_TIMEOUT) begin
      n = 0;
      while (tx !== 1'b0 && n < 400) begin
        @(negedge clk);
        n++;
      end
      tests++;
      if (n < TO || n > TO + 12) begin
        fails++;
        $display("FAIL timeout_gap: got %0d cycles, expected %0d..%0d",
                 n, TO, TO + 12);
      end
    end else begin
      repeat (3 + $urandom_range(0, 6)) @(negedge clk);
      if (kind == K_GLITCH) begin
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (6) @(negedge clk);
      end
      if (kind == K_HIERR) begin
        send_byte(hi, 1'b0);
      end else begin
        send_byte(hi, 1'b1);
        repeat ($urandom_range(0, 6)) @(negedge clk);
        if (kind == K_LOERR) begin
          send_byte(lo, 1'b0);
        end else begin
          pend_ch  = exp_ch;
          pend_val = {hi[1:0], lo};
          pend_en  = 1'b1;
          send_byte(lo, 1'b1);
          repeat (4) @(negedge clk);
          exp_val[pend_ch] = pend_val;
          pend_en = 1'b0;
        end
      end
    end
    exp_ch = (exp_ch + 1) % 4;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [9:0] frm;
    logic       eb;
    int         r;
    int         kind;

    for (int i = 0; i < 4; i++) exp_val[i] = 10'd0;
    hi_t = '{8'h01, 8'h00, 8'h02, 8'hFE};
    lo_t = '{8'h23, 8'h45, 8'h00, 8'h10};

    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_v1", v1, 0);
    chk("rst_v2", v2, 0);
    chk("rst_v3", v3, 0);
    chk("rst_v4", v4, 0);

    rst    = 1'b0;
    chk_en = 1'b1;
    frm    = {1'b1, 8'hA1, 1'b0};
    for (int i = 0; i < 44; i++) begin
      eb = (i < 4) ? 1'b1 : frm[(i - 4) / 4];
      chk("first_frame", tx, eb);
      @(negedge clk);
    end
    @(negedge clk);
    send_byte(8'h03, 1'b1);
    repeat (2) @(negedge clk);
    pend_ch  = 0;
    pend_val = 10'h3FF;
    pend_en  = 1'b1;
    send_byte(8'hFF, 1'b1);
    repeat (4) @(negedge clk);
    exp_val[0] = pend_val;
    pend_en = 1'b0;
    exp_ch  = 1;
    chk("ch1_v1", v1, 10'h3FF);
    chk("ch1_v2", v2, 0);
    chk("ch1_v3", v3, 0);
    chk("ch1_v4", v4, 0);

    txn(K_VALID, 8'h7C, 8'h11);
    txn(K_VALID, 8'h81, 8'h5A);
    txn(K_VALID, 8'h33, 8'hE7);

    for (int i = 0; i < 4; i++) txn(K_VALID, hi_t[i], lo_t[i]);
    chk("tbl_v1", v1, 10'h123);
    chk("tbl_v2", v2, 10'h045);
    chk("tbl_v3", v3, 10'h200);
    chk("tbl_v4", v4, 10'h210);

    txn(K_VALID, 8'h00, 8'h9A);
    chk("after_wrap_v1", v1, 10'h09A);
    txn(K_TIMEOUT, 8'h00, 8'h00);
    chk("timeout_v2", v2, 10'h045);
    txn(K_HIERR, 8'h01, 8'h00);
    chk("hierr_v3", v3, 10'h200);
    txn(K_GLITCH, 8'h5E, 8'hC3);
    chk("glitch_v4", v4, 10'h2C3);

    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 9);
      kind = (r < 5) ? K_VALID : (r == 5) ? K_TIMEOUT :
             (r == 6) ? K_HIERR : (r == 7) ? K_LOERR : K_GLITCH;
      txn(kind, 8'($urandom), 8'($urandom));
    end

    wait_cmd(8'hA1 + 8'(exp_ch));
    repeat (4) @(negedge clk);
    send_byte(8'h02, 1'b1);
    repeat (2) @(negedge clk);
    rx = 1'b0;
    repeat (CPB * 3) @(negedge clk);
    chk_en  = 1'b0;
    rst     = 1'b1;
    rx      = 1'b1;
    pend_en = 1'b0;
    for (int i = 0; i < 4; i++) exp_val[i] = 10'd0;
    exp_ch = 0;
    repeat (3) @(negedge clk);
    chk("midrst_tx", tx, 1);
    chk("midrst_v1", v1, 0);
    chk("midrst_v4", v4, 0);
    rst    = 1'b0;
    chk_en = 1'b1;
    txn(K_VALID, 8'h01, 8'h55);
    chk("post_rst_v1", v1, 10'h155);
    chk("post_rst_v2", v2, 0);
    repeat (10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adc_reader.md
ADC_READER -- requirements
Module: adc_reader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 1250, giving clock cycles per UART bit (9600 baud at 12 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 120000, giving the maximum wait for a complete reply after the command stop bit (10 ms).
REQ-003 SHALL have port clock12MHz, input, 1 bit, the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port serialIn, input, 1 bit, UART RX from the ADC controller; idle high; asynchronous to clock12MHz.
REQ-006 SHALL have port serialOut, output, 1 bit, UART TX to the ADC controller; idle high.
REQ-007 SHALL have ports value1, value2, value3, value4, each an output of 10 bits, holding the latest conversion of ADC channels 1..4.

Function
REQ-008 SHALL pass serialIn through a 2-flop synchronizer before any use.
REQ-009 SHALL frame UART as 8N1, LSB first, each bit held exactly CLKS_PER_BIT cycles.
REQ-010 SHALL poll channels round-robin 1,2,3,4,1,... forever; each transaction is: TX command, RX high byte, RX low byte.
REQ-011 SHALL use command byte 0xA0+n for channel n (0xA1..0xA4).
REQ-012 SHALL use states IDLE_GAP, TX_CMD, RX_HI, RX_LO, UPDATE; IDLE_GAP holds serialOut high for one bit time (CLKS_PER_BIT cycles) and then enters TX_CMD.
REQ-013 SHALL, in TX_CMD, send start(0), 8 data bits and stop(1), then go to RX_HI and start the timeout counter.
REQ-014 SHALL detect an RX start bit on a high-to-low transition of the synchronized input and re-check it low at CLKS_PER_BIT/2 (integer division); if it reads high, the receiver SHALL ignore it as a glitch and rearm.
REQ-015 SHALL sample each data bit and the stop bit at the mid-bit point, CLKS_PER_BIT cycles after the previous sample.
REQ-016 SHALL take value bits [9:8] from high-byte bits [1:0] and ignore high-byte bits [7:2].
REQ-017 SHALL take value bits [7:0] from the full low byte.
REQ-018 SHALL, on the cycle after the low-byte stop sample (UPDATE), load all 10 bits of value<n> at once; the other three outputs stay unchanged.
REQ-019 SHALL treat a stop bit sampled low in either byte as a framing error: discard the transaction, leave value<n> unchanged, and advance to the next channel via IDLE_GAP.
REQ-020 SHALL treat the timeout counter reaching TIMEOUT_CYCLES before UPDATE as a failure, handled identically to REQ-019.
REQ-021 SHALL ignore RX activity outside RX_HI and RX_LO.
REQ-022 SHALL wrap the channel index from 4 to 1.
REQ-023 SHALL drive serialOut from a register, glitch-free.

Reset
REQ-024 SHALL, while reset is high, drive serialOut=1 and value1..value4=0, clear all counters and synchronizer flops (to 1), set the channel to 1, and enter IDLE_GAP.
REQ-025 SHALL, when reset is asserted mid-transaction, abort the transaction immediately and leave no partial update; after release, polling restarts at channel 1.

Verification (CLKS_PER_BIT=4, TIMEOUT_CYCLES=200)
REQ-026 SHALL pass: reset released -> serialOut stays high 4 cycles, then the frame 0,1,0,0,0,0,1,0,1,1 (0xA1 LSB first), each level held 4 cycles.
REQ-027 SHALL pass: reply 0x03 then 0xFF after the 0xA1 command -> value1=0x3FF one cycle after the low stop sample; value2..value4 stay 0.
REQ-028 SHALL pass: four channels answered with {0x01,0x23},{0x00,0x45},{0x02,0x00},{0xFE,0x10} -> values 0x123, 0x045, 0x200, 0x210; the next command is 0xA1.
REQ-029 SHALL pass: no reply to 0xA2 -> after 200 cycles the block sends 0xA3 and value2 is unchanged.
REQ-030 SHALL pass: high byte with stop bit forced low -> the transaction is discarded and the next channel is polled.
REQ-031 SHALL pass: 1-cycle low glitch on serialIn during RX_HI -> ignored, and a following valid reply is decoded correctly.
